// File: rtl/fpu_addsub_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// fpu_addsub_issue_ctrl_if
// Bundles every signal between the add/sub issue controller and its
// surroundings: the two requesters, the shared 5-stage datapath and the
// response side. Clock and reset stay as plain module ports.
//   slave  : the issue controller's view
//   master : the environment's view (requesters, datapath, sinks)
// Signal groups:
//   Flush                          synchronous discard of in-flight ops
//   ReqValid/ReqOp/ReqA/ReqB/ReqReady   requester 0 and 1 issue handshakes
//   PipeEnable/PipeInA/PipeInB/PipeOp   datapath stage-1 drive + advance
//   PipeResult/PipeOverflow        datapath stage-5 result
//   RespValid/RespReady/RespData/RespOverflow  response handshakes
//   InFlight/Busy                  occupancy status
// ---------------------------------------------------------------------------
interface fpu_addsub_issue_ctrl_if #(
  parameter int DataSize  = 32,
  parameter int CountSize = 3
);
  logic                 Flush;
  logic                 ReqValid0, ReqValid1;
  logic                 ReqOp0, ReqOp1;
  logic [DataSize-1:0]  ReqA0, ReqB0, ReqA1, ReqB1;
  logic                 ReqReady0, ReqReady1;
  logic                 PipeEnable;
  logic [DataSize-1:0]  PipeInA, PipeInB;
  logic                 PipeOp;
  logic [DataSize-1:0]  PipeResult;
  logic                 PipeOverflow;
  logic                 RespValid0, RespValid1;
  logic [DataSize-1:0]  RespData;
  logic                 RespOverflow;
  logic                 RespReady0, RespReady1;
  logic [CountSize-1:0] InFlight;
  logic                 Busy;

  modport slave (
    input  Flush, ReqValid0, ReqValid1, ReqOp0, ReqOp1,
           ReqA0, ReqB0, ReqA1, ReqB1,
           PipeResult, PipeOverflow, RespReady0, RespReady1,
    output ReqReady0, ReqReady1, PipeEnable, PipeInA, PipeInB, PipeOp,
           RespValid0, RespValid1, RespData, RespOverflow, InFlight, Busy
  );

  modport master (
    output Flush, ReqValid0, ReqValid1, ReqOp0, ReqOp1,
           ReqA0, ReqB0, ReqA1, ReqB1,
           PipeResult, PipeOverflow, RespReady0, RespReady1,
    input  ReqReady0, ReqReady1, PipeEnable, PipeInA, PipeInB, PipeOp,
           RespValid0, RespValid1, RespData, RespOverflow, InFlight, Busy
  );
endinterface

// File: rtl/fpu_addsub_issue_ctrl.sv
// ---------------------------------------------------------------------------
// fpu_addsub_issue_ctrl
// Issue/retire controller for the shared 5-stage FP add/sub datapath.
// Two requesters are arbitrated round-robin onto the pipeline; a shadow
// shift register carries a valid bit and requester ID beside each operation
// so the stage-5 result (and its overflow flag) is steered back to the
// requester that issued it. A tail result whose owner is not ready freezes
// the whole pipeline through PipeEnable.
// Ports:
//   Clk    rising-edge clock
//   Reset  synchronous, active-high
//   bus    fpu_addsub_issue_ctrl_if.slave (requests, datapath, responses)
// ---------------------------------------------------------------------------
module fpu_addsub_issue_ctrl #(
  parameter int DataSize  = 32,
  parameter int Stages    = 5,
  parameter int CountSize = 3
) (
  input logic                  Clk,
  input logic                  Reset,
  fpu_addsub_issue_ctrl_if.slave bus
);

  // Shadow pipeline: slot 0 holds the newest issue, slot Stages-1 lines up
  // with PipeResult.
  logic [Stages-1:0]    slotValid;
  logic [Stages-1:0]    slotId;
  logic                 last;        // last granted requester
  logic [CountSize-1:0] inFlight;

  logic                 tailValid, tailId, tailReady;
  logic                 pipeEnable;
  logic                 grantValid, grantId;
  logic                 accept, retire;
  logic [DataSize-1:0]  grantA, grantB;
  logic                 grantOp;

  always_comb begin
    // NOTE: every signal driven here gets a value before any condition, so
    // no path leaves one unassigned and no latch is inferred.
    tailValid  = slotValid[Stages-1];
    tailId     = slotId[Stages-1];
    tailReady  = tailId ? bus.RespReady1 : bus.RespReady0;

    // Only an unclaimed tail result stalls; Flush always lets the datapath
    // advance because its contents are discarded anyway.
    pipeEnable = !(tailValid && !tailReady) || bus.Flush;

    // Round-robin: on a tie the requester other than the last winner goes.
    grantValid = bus.ReqValid0 || bus.ReqValid1;
    grantId    = (bus.ReqValid0 && bus.ReqValid1) ? ~last : bus.ReqValid1;

    accept     = grantValid && pipeEnable && !bus.Flush;
    retire     = tailValid && tailReady && !bus.Flush;

    grantA     = '0;
    grantB     = '0;
    grantOp    = 1'b0;
    if (grantValid) begin
      grantA  = grantId ? bus.ReqA1  : bus.ReqA0;
      grantB  = grantId ? bus.ReqB1  : bus.ReqB0;
      grantOp = grantId ? bus.ReqOp1 : bus.ReqOp0;
    end

    bus.PipeEnable   = pipeEnable;
    bus.PipeInA      = grantA;
    bus.PipeInB      = grantB;
    bus.PipeOp       = grantOp;
    bus.ReqReady0    = accept && !grantId;
    bus.ReqReady1    = accept &&  grantId;
    bus.RespValid0   = tailValid && !tailId && !bus.Flush;
    bus.RespValid1   = tailValid &&  tailId && !bus.Flush;
    bus.RespData     = bus.PipeResult;
    bus.RespOverflow = bus.PipeOverflow;
    bus.InFlight     = inFlight;
    bus.Busy         = (inFlight != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      // NOTE: the ID shift register is small and its reset value is
      // observable through steering, so it is reset along with the valids.
      slotValid <= '0;
      slotId    <= '0;
      last      <= 1'b1;
      inFlight  <= '0;
    end else if (bus.Flush) begin
      slotValid <= '0;
      inFlight  <= '0;
    end else if (pipeEnable) begin
      slotValid <= {slotValid[Stages-2:0], accept};
      slotId    <= {slotId[Stages-2:0], grantId};
      if (accept) begin
        last <= grantId;
      end
      // Issue and retire in the same cycle cancel out.
      case ({accept, retire})
        2'b10:   inFlight <= inFlight + CountSize'(1);
        2'b01:   inFlight <= inFlight - CountSize'(1);
        default: inFlight <= inFlight;
      endcase
    end
  end

endmodule

// File: doc/fpu_addsub_issue_ctrl.md
# fpu_addsub_issue_ctrl

Issue/retire controller for the 5-stage pipelined floating-point add/sub datapath. It arbitrates two requesters onto the single shared pipeline and drives a global advance enable into every stage register. It carries a valid bit and requester ID alongside each operation and steers each stage-5 result, with its exponent-overflow flag, back to the requester that issued it. Ready/valid handshakes are used on both sides.

## Interface
- DataSize, 32, operand/result width (single precision)
- Stages, 5, pipeline depth in enabled clock edges from issue to result
- CountSize, 3, width of InFlight; must hold Stages

- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high
- Flush  in  1  synchronous discard of all in-flight operations
- ReqValid0 / ReqValid1  in  1  requester N has an operation
- ReqOp0 / ReqOp1  in  1  0 = add, 1 = subtract
- ReqA0, ReqB0 / ReqA1, ReqB1  in  DataSize  operands
- ReqReady0 / ReqReady1  out  1  requester N accepted this cycle
- PipeEnable  out  1  advance enable for all datapath stage registers
- PipeInA, PipeInB  out  DataSize  stage-1 operands (granted requester's, else 0)
- PipeOp  out  1  stage-1 operation
- PipeResult  in  DataSize  stage-5 packed result
- PipeOverflow  in  1  stage-5 exponent adder carry
- RespValid0 / RespValid1  out  1  result for requester N
- RespData  out  DataSize  = PipeResult
- RespOverflow  out  1  = PipeOverflow
- RespReady0 / RespReady1  in  1  requester N takes the result
- InFlight  out  CountSize  valid operations in the pipeline
- Busy  out  1  InFlight != 0

## Operation
- Shadow pipeline: Stages-deep shift registers of Valid and Id. Both shift only on edges where PipeEnable=1. Slot 0 loads the issue; the tail is slot Stages-1 and aligns with PipeResult.
- Tail handshake: RespValidN = TailValid && TailId==N && !Flush. Retire occurs when RespValidN && RespReadyN.
- Stall: PipeEnable = !(TailValid && !RespReady[TailId]) || Flush. A stalled tail freezes the whole pipeline. Bubbles are not compressed.
- Arbitration: round-robin. Pointer Last holds the last granted ID.
  - If both requesters are valid, grant the ID != Last.
  - If one is valid, grant it.
  - ReqReadyN = PipeEnable && !Flush && grant==N.
  - Last updates only on an accepted issue.
- Issue: slot 0 gets Valid = (any accepted), Id = grant. PipeInA/B/Op are muxed from the granted requester. With no grant, a bubble (Valid=0) enters.
- InFlight: +1 on issue, −1 on retire, unchanged if both occur in the same cycle. It never exceeds Stages.
- Flush: all Valid bits cleared on the edge. No issue and no retire that cycle. InFlight goes to 0. Last is unchanged. Datapath registers still advance, and their contents are ignored.
- Ordering: results return strictly in issue order, one per cycle at most.

## Timing
- Reset (and Reset mid-operation): all Valid=0, Id=0, Last=1 (so requester 0 wins the first tie), InFlight=0.
  - Outputs after reset: ReqReady* follow the grant (PipeEnable=1), RespValid*=0, Busy=0, PipeEnable=1.
  - In-flight results are discarded.
- Reset has priority over Flush.
- Latency: an operation accepted at edge k appears on RespValid/RespData in the cycle after edge k+Stages−1, counting only edges with PipeEnable=1. With no stalls, the response is visible in cycle k+Stages.
- Throughput: 1 issue and 1 retire per cycle. A full pipeline with a continuously ready sink never stalls.
- All control outputs are combinational from state plus current inputs. There is no combinational path from ReqValid to RespValid.

## Test plan
- Single issue: Reset, then requester 0 issues 1.0+2.0 (0x3F800000, 0x40000000) with RespReady0=1 -> ReqReady0=1; RespValid0=1 with RespData=0x40400000 exactly 5 cycles later; InFlight goes 1..1..0.
- Round-robin: both requesters valid for 6 cycles -> grants alternate 0,1,0,1,0,1; responses return in the same order, each on its own RespValid line.
- Backpressure: fill with 5 ops from requester 1, hold RespReady1=0 for 3 cycles -> PipeEnable=0, ReqReady*=0, RespValid1 held with stable RespData; release -> 5 results drain on consecutive cycles.
- Overflow steering: requester 0 issues 0x7F7FFFFF+0x7F7FFFFF -> RespOverflow=1 together with RespValid0.
- Flush/reset mid-flight: 3 ops in flight; assert Flush for 1 cycle with ReqValid0=1 -> ReqReady0=0 that cycle, InFlight=0 next cycle, no RespValid ever produced for the flushed ops. Repeating with Reset gives the same result, plus Last=1.
